// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared header for the FIFO family (single-clock and dual-clock variants).
//   Provides default geometry constants, a packed status-flag bundle and
//   constant helper functions usable in parameter/port declarations.
//   No ports.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Registered occupancy flags, kept together so they update as one unit.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_W register array with one synchronous write port and one
//   asynchronous (combinational) read port.
//   Ports:
//     clk      in   write clock
//     i_we     in   write enable
//     i_waddr  in   write address
//     i_wdata  in   write data
//     i_raddr  in   read address
//     o_rdata  out  read data, combinational from i_raddr
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the storage array has no reset; contents before the first write
    // are never observed because the FIFO reports empty until then, and
    // leaving it unreset lets synthesis map it onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parametrised FIFO with occupancy count, programmable
//   almost-full/almost-empty, sticky overflow/underflow flags and a
//   selectable first-word-fall-through read mode.
//   Ports:
//     clk           in   rising-edge clock
//     rst           in   asynchronous active-high reset
//     wr_en/wr_data in   write request and data
//     rd_en         in   read request (FWFT: pop the head)
//     rd_data       out  read data
//     rd_valid      out  rd_data holds a valid word
//     full/empty    out  count == DEPTH / count == 0
//     almost_full   out  count >= AF_THRESH
//     almost_empty  out  count <= AE_THRESH
//     count         out  occupancy 0..DEPTH
//     overflow      out  sticky: write attempted while full
//     underflow     out  sticky: read attempted while empty
//     clr_err       in   synchronous clear of overflow/underflow
// ---------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Elaboration-time parameter sanity.
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: require AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    fifo_flags_t       r_flags;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] w_mem_rdata;

    // Accept decisions use the registered flags, so a full FIFO rejects a
    // write even when a read happens in the same cycle, and an empty FIFO
    // rejects a read even when a write happens (no bypass path).
    assign w_wr_acc = wr_en && !r_flags.full;
    assign w_rd_acc = rd_en && !r_flags.empty;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cnt_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_next = r_count + CNT_W'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_next = r_count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr             <= '0;
            r_rd_ptr             <= '0;
            r_count              <= '0;
            r_flags.full         <= 1'b0;
            r_flags.empty        <= 1'b1;
            r_flags.almost_full  <= 1'b0;
            r_flags.almost_empty <= 1'b1;
            r_overflow           <= 1'b0;
            r_underflow          <= 1'b0;
        end else begin
            // Pointers are exactly ADDR_W bits wide, so DEPTH-1 wraps to 0.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_cnt_next;

            // Flags come from the next count so they move with count.
            r_flags.full         <= (w_cnt_next == CNT_W'(DEPTH));
            r_flags.empty        <= (w_cnt_next == '0);
            r_flags.almost_full  <= (w_cnt_next >= CNT_W'(AF_THRESH));
            r_flags.almost_empty <= (w_cnt_next <= CNT_W'(AE_THRESH));

            // A new error event wins over a clear in the same cycle.
            if (wr_en && r_flags.full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_flags.empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head of queue is presented directly; forced to zero while empty so
        // stale storage never shows on the port (including right after reset).
        assign rd_data  = r_flags.empty ? '0 : w_mem_rdata;
        assign rd_valid = !r_flags.empty;
    end else begin : g_std
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= w_mem_rdata;
                end
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

    assign count        = r_count;
    assign full         = r_flags.full;
    assign empty        = r_flags.empty;
    assign almost_full  = r_flags.almost_full;
    assign almost_empty = r_flags.almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Drives one standard-read and one FWFT instance (DATA_W=8, DEPTH=8,
//   AF_THRESH=6, AE_THRESH=2) with identical stimulus and compares both
//   against a queue-based reference on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEP   = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clr_err;

    logic [DW-1:0] rd_data0,  rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1;
    logic [3:0]    count0, count1;
    logic          ovf0, ovf1, udf0, udf1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] m_std_data;
    bit            m_std_valid;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
    );

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        m_std_data  = '0;
        m_std_valid = 1'b0;
    endtask

    // One clock edge of the reference, using pre-edge occupancy.
    task automatic model_edge(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEP);
        was_empty = (q.size() == 0);
        if (rd && !was_empty) begin
            m_std_data  = q.pop_front();
            m_std_valid = 1'b1;
        end else begin
            m_std_valid = 1'b0;
        end
        if (wr && !was_full) q.push_back(wd);
        if (wr && was_full)  m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        if (rd && was_empty) m_udf = 1'b1;
        else if (clr)        m_udf = 1'b0;
    endtask

    // Apply one cycle of stimulus; returns 1 ns after the rising edge.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        model_edge(wr, wd, rd, clr);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Continuous comparison against the reference on every falling edge.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        check("count0",        32'(count0), 32'(sz));
        check("count1",        32'(count1), 32'(sz));
        check("full0",         32'(full0),  32'(sz == DEP));
        check("full1",         32'(full1),  32'(sz == DEP));
        check("empty0",        32'(empty0), 32'(sz == 0));
        check("empty1",        32'(empty1), 32'(sz == 0));
        check("almost_full0",  32'(af0),    32'(sz >= AF));
        check("almost_full1",  32'(af1),    32'(sz >= AF));
        check("almost_empty0", 32'(ae0),    32'(sz <= AE));
        check("almost_empty1", 32'(ae1),    32'(sz <= AE));
        check("overflow0",     32'(ovf0),   32'(m_ovf));
        check("overflow1",     32'(ovf1),   32'(m_ovf));
        check("underflow0",    32'(udf0),   32'(m_udf));
        check("underflow1",    32'(udf1),   32'(m_udf));
        check("rd_valid0",     32'(rd_valid0), 32'(m_std_valid));
        check("rd_data0",      32'(rd_data0),  32'(m_std_data));
        check("rd_valid1",     32'(rd_valid1), 32'(sz != 0));
        check("rd_data1",      32'(rd_data1),  (sz != 0) ? 32'(q[0]) : 32'h0);
    end

    initial begin
        logic [DW-1:0] pat [5];
        pat[0] = 8'h34; pat[1] = 8'hA8; pat[2] = 8'h0F; pat[3] = 8'hAB; pat[4] = 8'h09;

        model_reset();
        do_reset();
        step(0, 0, 0, 0);
        check("lit_reset_empty",  32'(empty0),    32'd1);
        check("lit_reset_ae",     32'(ae0),       32'd1);
        check("lit_reset_full",   32'(full0),     32'd0);
        check("lit_reset_count",  32'(count0),    32'd0);
        check("lit_reset_valid",  32'(rd_valid0), 32'd0);
        check("lit_reset_errors", 32'({ovf0, udf0}), 32'd0);

        // Ordered data through the standard read port.
        for (int i = 0; i < 5; i++) step(1, pat[i], 0, 0);
        check("lit_fwft_head", 32'(rd_data1), 32'h34);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            check("lit_std_rd_valid", 32'(rd_valid0), 32'd1);
            check("lit_std_rd_data",  32'(rd_data0),  32'(pat[i]));
        end
        check("lit_empty_after_reads", 32'(empty0), 32'd1);

        // Fill, almost_full, full, overflow.
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(8'h40 + i), 0, 0);
            if (i == 5) check("lit_af_at5", 32'(af0), 32'd0);
            if (i == 6) check("lit_af_at6", 32'(af0), 32'd1);
            if (i == 7) check("lit_full_at7", 32'(full0), 32'd0);
        end
        check("lit_full_at8", 32'(full0), 32'd1);
        step(1, 8'hEE, 0, 0);
        check("lit_ovf_count", 32'(count0), 32'd8);
        check("lit_ovf_set",   32'(ovf0),   32'd1);
        step(0, 0, 0, 0);
        check("lit_ovf_sticky", 32'(ovf0), 32'd1);
        step(1, 8'hEF, 1, 0); // full: read accepted, write rejected
        check("lit_full_rdwr_count", 32'(count0), 32'd7);
        check("lit_full_rdwr_data",  32'(rd_data0), 32'h41);
        step(0, 0, 0, 1);
        check("lit_ovf_cleared", 32'(ovf0), 32'd0);

        // Drain, then underflow behaviour.
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("lit_udf_set",   32'(udf0),      32'd1);
        check("lit_udf_valid", 32'(rd_valid0), 32'd0);
        check("lit_udf_count", 32'(count0),    32'd0);
        step(0, 0, 1, 1);
        check("lit_udf_set_beats_clr", 32'(udf0), 32'd1);
        step(1, 8'h77, 1, 0); // empty: write accepted, read rejected
        check("lit_empty_rdwr_count", 32'(count0), 32'd1);
        check("lit_empty_rdwr_valid", 32'(rd_valid0), 32'd0);
        step(0, 0, 0, 1);
        check("lit_udf_cleared", 32'(udf0), 32'd0);
        step(0, 0, 1, 0);

        // Steady occupancy 4 with simultaneous read/write; pointers wrap.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h20 + i), 1, 0);
            check("lit_steady_count", 32'(count0), 32'd4);
        end
        check("lit_steady_last_rd", 32'(rd_data0), 32'h25);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        check("lit_steady_drain", 32'(rd_data0), 32'h29);

        // FWFT visibility and pop.
        step(1, 8'h5A, 0, 0);
        check("lit_fwft_data",  32'(rd_data1),  32'h5A);
        check("lit_fwft_valid", 32'(rd_valid1), 32'd1);
        step(0, 0, 1, 0);
        check("lit_fwft_empty", 32'(empty1), 32'd1);

        // Randomized phases: write-heavy, read-heavy, balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 600; i++) begin
                bit wr, rd, clr;
                wr  = (ph == 0) ? ($urandom_range(3) != 0) :
                      (ph == 1) ? ($urandom_range(3) == 0) : $urandom_range(1) == 1;
                rd  = (ph == 0) ? ($urandom_range(3) == 0) :
                      (ph == 1) ? ($urandom_range(3) != 0) : $urandom_range(1) == 1;
                clr = ($urandom_range(31) == 0);
                step(wr, 8'($urandom), rd, clr);
                if (ph == 0 && i == 300) begin
                    // Asynchronous reset in the middle of a burst.
                    wr_en = 1'b1; wr_data = 8'hC3; rd_en = 1'b1;
                    #2 rst = 1'b1;
                    model_reset();
                    #1;
                    check("lit_midrst_count0", 32'(count0),    32'd0);
                    check("lit_midrst_empty1", 32'(empty1),    32'd1);
                    check("lit_midrst_full0",  32'(full0),     32'd0);
                    check("lit_midrst_valid0", 32'(rd_valid0), 32'd0);
                    check("lit_midrst_valid1", 32'(rd_valid1), 32'd0);
                    check("lit_midrst_data0",  32'(rd_data0),  32'd0);
                    check("lit_midrst_data1",  32'(rd_data1),  32'd0);
                    check("lit_midrst_err",    32'({ovf0, udf0, ovf1, udf1}), 32'd0);
                    wr_en = 1'b0; rd_en = 1'b0;
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
